// File: rtl/lap_pointer_reader.sv
// lap_pointer_reader: consumer-side pointer of a circular buffer whose
// producer is a lap-bit wrapping counter. Pointers are {lap, index}. The
// lap bit separates the "same position, nothing stored" case from the
// "same position, completely full" case.
module lap_pointer_reader #(
    parameter int RANGE       = 4,
    parameter int INDEX_WIDTH = $clog2(RANGE),
    parameter int WIDTH       = INDEX_WIDTH + 1,
    parameter int LEVEL_WIDTH = $clog2(RANGE + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       write_pointer,
    input  logic                   read_enable,
    input  logic                   flush,
    output logic [WIDTH-1:0]       read_pointer,
    output logic [INDEX_WIDTH-1:0] read_index,
    output logic                   empty,
    output logic                   full,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   wrapped,
    output logic                   underflow
);

    // One extra bit of headroom so that the different-lap sum
    // RANGE - r_idx + w_idx is formed without overflow.
    localparam int                     SPAN_WIDTH = LEVEL_WIDTH + 1;
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(RANGE - 1);
    localparam logic [SPAN_WIDTH-1:0]  RANGE_SPAN = SPAN_WIDTH'(RANGE);

    logic [WIDTH-1:0]       read_pointer_r;
    logic                   wrapped_r;
    logic                   underflow_r;

    logic [WIDTH-1:0]       read_pointer_next_s;
    logic                   wrapped_next_s;
    logic                   underflow_next_s;

    logic                   read_lap_s;
    logic                   write_lap_s;
    logic [INDEX_WIDTH-1:0] read_index_s;
    logic [INDEX_WIDTH-1:0] write_index_s;
    logic                   empty_s;
    logic                   full_s;
    logic [SPAN_WIDTH-1:0]  span_s;
    logic                   pop_s;
    logic                   last_s;

    // Occupancy status: pure function of the current read and write pointers.
    always_comb begin
        read_lap_s    = read_pointer_r[WIDTH-1];
        write_lap_s   = write_pointer[WIDTH-1];
        read_index_s  = read_pointer_r[INDEX_WIDTH-1:0];
        write_index_s = write_pointer[INDEX_WIDTH-1:0];
        empty_s       = (read_pointer_r == write_pointer);
        full_s        = (read_index_s == write_index_s) && (read_lap_s != write_lap_s);
        if (read_lap_s == write_lap_s) begin
            span_s = SPAN_WIDTH'(write_index_s) - SPAN_WIDTH'(read_index_s);
        end else begin
            span_s = RANGE_SPAN - SPAN_WIDTH'(read_index_s) + SPAN_WIDTH'(write_index_s);
        end
    end

    // Next read pointer and pulse values; flush overrides any pop request.
    always_comb begin
        pop_s               = read_enable && !empty_s && !flush;
        last_s              = (read_index_s == LAST_INDEX);
        read_pointer_next_s = read_pointer_r;
        wrapped_next_s      = 1'b0;
        underflow_next_s    = 1'b0;
        if (flush) begin
            read_pointer_next_s = write_pointer;
        end else if (pop_s) begin
            if (last_s) begin
                // Index RANGE-1 wraps to 0 and the lap bit flips, even when
                // RANGE is not a power of two.
                read_pointer_next_s = {~read_lap_s, {INDEX_WIDTH{1'b0}}};
                wrapped_next_s      = 1'b1;
            end else begin
                read_pointer_next_s = {read_lap_s, read_index_s + INDEX_WIDTH'(1'b1)};
            end
        end else if (read_enable) begin
            // Only reachable when empty: the pop is refused and flagged.
            underflow_next_s = 1'b1;
        end else begin
            read_pointer_next_s = read_pointer_r;
        end
    end

    // State registers: read pointer and the two single-cycle pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_pointer_r <= {WIDTH{1'b0}};
            wrapped_r      <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            read_pointer_r <= read_pointer_next_s;
            wrapped_r      <= wrapped_next_s;
            underflow_r    <= underflow_next_s;
        end
    end

    // Output drive: registered pointer/pulses plus combinational status.
    always_comb begin
        read_pointer = read_pointer_r;
        read_index   = read_pointer_r[INDEX_WIDTH-1:0];
        wrapped      = wrapped_r;
        underflow    = underflow_r;
        empty        = empty_s;
        full         = full_s;
        level        = LEVEL_WIDTH'(span_s);
    end

endmodule

// File: tb/tb_lap_pointer_reader.sv
// Bench for lap_pointer_reader: a RANGE=4 instance driven from a vector
// table, and a RANGE=5 instance driven by hand-written corner sequences
// and random traffic compared with an absolute-position model.
module tb_lap_pointer_reader;

    localparam int R5 = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    // RANGE = 4 instance
    logic [2:0] wp4 = 3'b000;
    logic       re4 = 1'b0;
    logic       fl4 = 1'b0;
    logic [2:0] rp4;
    logic [1:0] ri4;
    logic       em4, fu4, wr4, uf4;
    logic [2:0] lv4;

    // RANGE = 5 instance
    logic [3:0] wp5 = 4'b0000;
    logic       re5 = 1'b0;
    logic       fl5 = 1'b0;
    logic [3:0] rp5;
    logic [2:0] ri5;
    logic       em5, fu5, wr5, uf5;
    logic [2:0] lv5;

    lap_pointer_reader #(.RANGE(4)) dut4 (
        .clock(clock), .reset(reset), .write_pointer(wp4), .read_enable(re4),
        .flush(fl4), .read_pointer(rp4), .read_index(ri4), .empty(em4),
        .full(fu4), .level(lv4), .wrapped(wr4), .underflow(uf4)
    );

    lap_pointer_reader #(.RANGE(R5)) dut5 (
        .clock(clock), .reset(reset), .write_pointer(wp5), .read_enable(re5),
        .flush(fl5), .read_pointer(rp5), .read_index(ri5), .empty(em5),
        .full(fu5), .level(lv5), .wrapped(wr5), .underflow(uf5)
    );

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] wp;
        logic       re;
        logic       fl;
        logic [2:0] rp;
        logic       emp;
        logic       ful;
        logic [2:0] lvl;
        logic       wr;
        logic       uf;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic [2:0] wp, input logic re, input logic fl,
                                input logic [2:0] rp, input logic emp, input logic ful,
                                input logic [2:0] lvl, input logic wr, input logic uf);
        vec_t v;
        v.wp = wp; v.re = re; v.fl = fl; v.rp = rp; v.emp = emp;
        v.ful = ful; v.lvl = lvl; v.wr = wr; v.uf = uf;
        return v;
    endfunction

    // Model: positions are absolute counts modulo 2*RANGE; the lap bit is
    // "count >= RANGE" and the index is "count mod RANGE".
    function automatic int m_level(input int r, input int w);
        return (w - r + 2 * R5) % (2 * R5);
    endfunction

    function automatic int m_ptr(input int a);
        return ((a >= R5) ? 8 : 0) + (a % R5);
    endfunction

    int r_abs, w_abs, lvl;
    bit m_wr, m_uf;

    initial begin
        // Vectors for RANGE=4, applied in order from reset (read pointer 000).
        //              wp     re    fl    rp     emp   ful   lvl    wr    uf
        vecs[0]  = mk(3'b011, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
        vecs[1]  = mk(3'b011, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
        vecs[2]  = mk(3'b011, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        vecs[3]  = mk(3'b011, 1'b1, 1'b0, 3'b011, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        vecs[4]  = mk(3'b111, 1'b0, 1'b0, 3'b011, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
        vecs[5]  = mk(3'b111, 1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
        vecs[6]  = mk(3'b111, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
        vecs[7]  = mk(3'b100, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        vecs[8]  = mk(3'b100, 1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
        vecs[9]  = mk(3'b100, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        vecs[10] = mk(3'b001, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        vecs[11] = mk(3'b110, 1'b1, 1'b1, 3'b110, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        vecs[12] = mk(3'b111, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        vecs[13] = mk(3'b000, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        vecs[14] = mk(3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        vecs[15] = mk(3'b000, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        vecs[16] = mk(3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
        vecs[17] = mk(3'b010, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);

        // Reset takes effect before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("reset rp4",  int'(rp4), 0);
        check("reset em4",  int'(em4), 1);
        check("reset fu4",  int'(fu4), 0);
        check("reset lv4",  int'(lv4), 0);
        check("reset wr4",  int'(wr4), 0);
        check("reset uf4",  int'(uf4), 0);
        check("reset rp5",  int'(rp5), 0);

        @(negedge clock);
        reset = 1'b0;

        // Table-driven sequence on the RANGE=4 instance.
        for (int i = 0; i < 18; i++) begin
            wp4 = vecs[i].wp;
            re4 = vecs[i].re;
            fl4 = vecs[i].fl;
            @(negedge clock);
            check($sformatf("v%0d rp", i),  int'(rp4), int'(vecs[i].rp));
            check($sformatf("v%0d idx", i), int'(ri4), int'(vecs[i].rp[1:0]));
            check($sformatf("v%0d empty", i), int'(em4), int'(vecs[i].emp));
            check($sformatf("v%0d full", i),  int'(fu4), int'(vecs[i].ful));
            check($sformatf("v%0d level", i), int'(lv4), int'(vecs[i].lvl));
            check($sformatf("v%0d wrapped", i),   int'(wr4), int'(vecs[i].wr));
            check($sformatf("v%0d underflow", i), int'(uf4), int'(vecs[i].uf));
        end
        re4 = 1'b0;
        fl4 = 1'b0;

        // RANGE=5: step the read pointer to index 4, lap 0.
        wp5 = 4'b0100;
        re5 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            check($sformatf("r5 step%0d rp", i), int'(rp5), i);
        end
        check("r5 empty at 0100", int'(em5), 1);
        wp5 = 4'b1010;
        re5 = 1'b0;
        @(negedge clock);
        check("r5 level 3", int'(lv5), 3);
        check("r5 not full", int'(fu5), 0);
        re5 = 1'b1;
        @(negedge clock);
        check("r5 wrap rp",      int'(rp5), 8);
        check("r5 wrap pulse",   int'(wr5), 1);
        check("r5 wrap level",   int'(lv5), 2);
        // Reset mid-cycle while a pop is still requested.
        #1 reset = 1'b1;
        #1;
        check("r5 async rst rp", int'(rp5), 0);
        check("r5 async rst wr", int'(wr5), 0);
        @(negedge clock);
        check("r5 rst hold rp", int'(rp5), 0);
        check("r5 rst hold wr", int'(wr5), 0);
        check("r5 rst hold uf", int'(uf5), 0);

        // Random traffic on RANGE=5 against the absolute-count model.
        wp5 = 4'b0000;
        re5 = 1'b0;
        fl5 = 1'b0;
        reset = 1'b0;
        r_abs = 0;
        w_abs = 0;
        m_wr  = 1'b0;
        m_uf  = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clock);
            lvl = m_level(r_abs, w_abs);
            check($sformatf("rnd%0d rp", c),    int'(rp5), m_ptr(r_abs));
            check($sformatf("rnd%0d idx", c),   int'(ri5), r_abs % R5);
            check($sformatf("rnd%0d empty", c), int'(em5), (lvl == 0) ? 1 : 0);
            check($sformatf("rnd%0d full", c),  int'(fu5), (lvl == R5) ? 1 : 0);
            check($sformatf("rnd%0d level", c), int'(lv5), lvl);
            check($sformatf("rnd%0d wrapped", c),   int'(wr5), int'(m_wr));
            check($sformatf("rnd%0d underflow", c), int'(uf5), int'(m_uf));

            if (lvl < R5 && $urandom_range(0, 99) < 50) begin
                w_abs = (w_abs + 1) % (2 * R5);
            end
            re5 = ($urandom_range(0, 99) < 55);
            fl5 = ($urandom_range(0, 99) < 6);
            wp5 = 4'(m_ptr(w_abs));

            lvl = m_level(r_abs, w_abs);
            if (fl5) begin
                r_abs = w_abs;
                m_wr  = 1'b0;
                m_uf  = 1'b0;
            end else if (re5 && lvl != 0) begin
                m_wr  = ((r_abs % R5) == R5 - 1);
                r_abs = (r_abs + 1) % (2 * R5);
                m_uf  = 1'b0;
            end else if (re5) begin
                m_wr = 1'b0;
                m_uf = 1'b1;
            end else begin
                m_wr = 1'b0;
                m_uf = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/lap_pointer_reader.md
Name: lap_pointer_reader

Overview:
- Read-side companion of the lap-bit wrapping write counter.
- Owns the read pointer of a circular buffer of RANGE entries, encoded as {lap, index}. Compares it against the externally supplied write pointer, in the same encoding, to produce empty, full and occupancy level.
- Accepts pop and flush requests and flags illegal pops.
- Used as the consumer end of FIFOs and ring buffers whose producer side is a lap-bit wrapping counter.

Parameters:
- RANGE, 4, number of buffer entries; any integer >= 2, non-power-of-two allowed.
- INDEX_WIDTH, $clog2(RANGE), derived; width of the index field.
- WIDTH, INDEX_WIDTH+1, derived; pointer width, lap bit at MSB (index WIDTH-1).
- LEVEL_WIDTH, $clog2(RANGE+1), derived; width of the level output.

Ports:
- clock  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- write_pointer  input  WIDTH  producer pointer {lap, index}; index < RANGE guaranteed by producer.
- read_enable  input  1  pop request; consumes one entry if not empty.
- flush  input  1  discard all entries: read pointer := write_pointer.
- read_pointer  output  WIDTH  registered read pointer {lap, index}.
- read_index  output  INDEX_WIDTH  read_pointer[INDEX_WIDTH-1:0], storage address.
- empty  output  1  pointers fully equal.
- full  output  1  indices equal, lap bits differ.
- level  output  LEVEL_WIDTH  number of stored entries, 0..RANGE.
- wrapped  output  1  registered pulse: previous pop moved index from RANGE-1 to 0.
- underflow  output  1  registered pulse: previous cycle had read_enable while empty, without flush.

Behaviour:
- Reset, asynchronous and immediate with no clock edge needed: read_pointer=0, wrapped=0, underflow=0. empty/full/level then follow from write_pointer.
- empty, full and level are combinational from the current read_pointer and write_pointer, with zero-cycle latency.
- empty = (read_pointer == write_pointer).
- full = (index fields equal) && (lap bits differ).
- Level computation:
  - laps equal: level = w_idx - r_idx.
  - laps differ: level = RANGE - r_idx + w_idx.
  - Performed at LEVEL_WIDTH+1 bits; never negative for legal inputs.
- Pop: read_enable && !empty && !flush at a rising edge advances the read pointer one position. The new pointer is visible on the next cycle.
  - r_idx < RANGE-1: r_idx+1, lap unchanged.
  - r_idx == RANGE-1: r_idx := 0, lap toggles, wrapped=1 for exactly one cycle.
- Illegal pop: read_enable && empty && !flush leaves read_pointer unchanged and sets underflow=1 for exactly one cycle.
- Flush has priority over read_enable:
  - read_pointer := write_pointer sampled at that edge.
  - No wrapped or underflow pulse.
  - empty=1 next cycle unless the producer advanced.
- Pulses: wrapped and underflow are 0 in every cycle not immediately following their trigger edge. Both are never 1 simultaneously.
- Full, then pop: legal; level decrements by 1 next cycle (assuming write_pointer is static).
- Concurrent producer advance and pop in the same cycle: each pointer moves independently and level stays constant.
- write_pointer with index >= RANGE: out of contract. The bench does not drive it and the RTL needs no handling for it.
- Reset asserted mid-pop: reset wins; no pulse is generated.
- No internal state other than read_pointer, wrapped and underflow registers.

Test Plan:
1. Reset: reset=1, write_pointer=3'b000 -> read_pointer=0, empty=1, full=0, level=0, wrapped=0, underflow=0.
2. RANGE=4, write_pointer=3'b011, read_enable=1 for 3 cycles:
   - Start: level=3, empty=0.
   - read_pointer steps 001, 010, 011, with level 2, 1, 0 each following cycle.
   - End: empty=1, no pulses.
3. read_pointer=3'b011, write_pointer=3'b111:
   - full=1, level=4.
   - Pop once -> read_pointer=3'b100 (lap toggled, index 0), wrapped=1 for one cycle, level=3, full=0.
4. Empty (read=write=3'b100), read_enable=1 for one cycle:
   - read_pointer stays 100.
   - underflow=1 exactly one cycle later, then 0.
   - wrapped=0.
5. read_pointer=3'b001, write_pointer=3'b110, flush=1 and read_enable=1 together -> read_pointer=3'b110 next cycle, empty=1, level=0, underflow=0, wrapped=0.
6. RANGE=5 (WIDTH=4), read_pointer stepped to 4'b0100, write_pointer=4'b1010:
   - level=3.
   - Pop -> read_pointer=4'b1000 with wrapped=1.
   - Then assert reset asynchronously between edges -> read_pointer=0 immediately.
